time_up_counter: RTL and testbench
==================================

TIME_UP_COUNTER -- requirements
Module: time_up_counter

Interface
REQ-001 Parameter TICK_DIV, default 1, meaning clk cycles per counted second (tick_in qualifies each cycle; a second elapses every TICK_DIV qualified cycles).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 tick_in  input  1  count-enable qualifier.
REQ-005 set_en  input  1  one-cycle load strobe for the time value.
REQ-006 set_hh, set_mm, set_ss  input  8 each  BCD load value, {tens[7:4], units[3:0]}.
REQ-007 alm_en  input  1  alarm arm.
REQ-008 alm_hh, alm_mm  input  8 each  BCD alarm time.
REQ-009 alm_ack  input  1  clears an active alarm.
REQ-010 hh, mm, ss  output  8 each  current BCD time, registered.
REQ-011 day_carry  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 wrap.
REQ-012 set_err  output  1  one-cycle pulse on a rejected load.
REQ-013 alarm  output  1  ringing level.

Function
REQ-014 Prescaler counts qualified cycles 0..TICK_DIV-1; a second-step occurs on the cycle it holds TICK_DIV-1 with tick_in=1, and the prescaler then returns to 0.
REQ-015 On a second-step, ss units increments 0..9; 9 -> 0 with carry into ss tens.
REQ-016 ss tens counts 0..5; 5 with carry-in -> 0 and carries into mm; mm follows the same 00..59 rule.
REQ-017 hh counts 00..23; units wraps at 9 except at 23, where the carry sets hh to 00.
REQ-018 day_carry is 1 for exactly the cycle following the step from 23:59:59 to 00:00:00, otherwise 0.
REQ-019 All digit updates of one second-step take effect on the same edge; no intermediate value is visible on the outputs.
REQ-020 A load is valid when every digit is at most 9, ss/mm tens at most 5, and hh at most 23.
REQ-021 set_en with a valid value loads hh/mm/ss on the next edge, clears the prescaler, and suppresses any second-step in that cycle.
REQ-022 set_en with an invalid value leaves the time and the prescaler unchanged and pulses set_err for one cycle; a second-step in the same cycle still proceeds.
REQ-023 When alm_en=1 and a second-step produces hh=alm_hh, mm=alm_mm, ss=00, alarm sets to 1 on that edge.
REQ-024 A load that produces a time equal to the alarm time does not set alarm.
REQ-025 alarm stays at 1 until alm_ack=1 or alm_en=0, and clears on the next edge.
REQ-026 When a set condition and alm_ack occur in the same cycle, the set wins and alarm=1.
REQ-027 An invalid (non-BCD) alarm time never matches; no error is flagged for it.

Reset
REQ-028 While rst=0 at an edge: hh=mm=ss=8'h00, prescaler=0, day_carry=0, set_err=0, alarm=0; reset overrides set_en, tick_in and alm_ack.
REQ-029 Reset asserted mid-count discards partial prescaler progress; counting resumes from 00:00:00 at the first qualified cycle after rst=1.

Structure
REQ-030 A shared package holds the BCD limits (digit max 9, tens max 5, hour max 23) and the 8-bit BCD time-field typedef.
REQ-031 The cascade is built from one sub-module, bcd_digit_up, instantiated six times: parameterised wrap value, with inputs cin/load/load_val, outputs a 4-bit value and cout, and an hour-units override input for the 23 -> 00 wrap.

Verification
REQ-032 Reset, TICK_DIV=1, tick_in held at 1 for 60 cycles -> ss counts 00..59; mm=01, ss=00 after the 60th step.
REQ-033 Load 23:59:58, then 2 steps -> 23:59:59, then 00:00:00; day_carry high for exactly one cycle.
REQ-034 set_en with 12:60:00 -> time unchanged, one-cycle set_err; set_en with 12:34:56 -> time reads 12:34:56 on the next cycle, no set_err.
REQ-035 alm_en=1, alarm 07:00, load 06:59:59, one step -> alarm=1; alm_ack -> alarm=0 on the next cycle; load 07:00:00 -> alarm stays 0.
REQ-036 TICK_DIV=4, tick_in toggling every cycle -> one second-step per 8 clk cycles; rst=0 after 3 qualified cycles -> 00:00:00 and the prescaler restarts from 0.

Source files
------------

// File: rtl/time_up_counter_pkg.sv
// Shared BCD limits, the time-field type and the load-value check for the
// time-of-day counter.
package time_up_counter_pkg;

  typedef logic [7:0] bcd_t;

  localparam logic [3:0] DIGIT_MAX      = 4'd9;
  localparam logic [3:0] TENS_MAX       = 4'd5;
  localparam int         HOUR_MAX       = 23;
  localparam logic [3:0] HOUR_TENS_MAX  = 4'(HOUR_MAX / 10);
  localparam logic [3:0] HOUR_UNITS_TOP = 4'(HOUR_MAX % 10);

  function automatic logic bcd_time_valid(input bcd_t hh, input bcd_t mm, input bcd_t ss);
    logic ok;
    ok = (ss[3:0] <= DIGIT_MAX) && (ss[7:4] <= TENS_MAX) &&
         (mm[3:0] <= DIGIT_MAX) && (mm[7:4] <= TENS_MAX) &&
         (hh[3:0] <= DIGIT_MAX) && (hh[7:4] <= HOUR_TENS_MAX);
    if (hh[7:4] == HOUR_TENS_MAX && hh[3:0] > HOUR_UNITS_TOP) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/time_up_counter_bcd_digit_up.sv
// One BCD digit of the cascade: counts 0..WRAP on cin, loads on load, and
// wraps early when force_wrap is set (the 23 -> 00 hour rollover).
module bcd_digit_up #(
  parameter logic [3:0] WRAP = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cin,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       force_wrap,
  output logic [3:0] val,
  output logic [3:0] val_nxt,
  output logic       cout
);

  logic [3:0] val_q;
  logic [3:0] val_d;
  logic       at_top;

  always_comb begin
    at_top = (val_q == WRAP) || force_wrap;
    cout   = cin && at_top;
    val_d  = val_q;
    if (load)
      val_d = load_val;
    else if (cin)
      val_d = at_top ? 4'd0 : val_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) val_q <= 4'd0;
    else      val_q <= val_d;
  end

  assign val     = val_q;
  assign val_nxt = val_d;

endmodule

// File: rtl/time_up_counter.sv
// BCD hh:mm:ss time-of-day counter with prescaler, validated load and a
// single hh:mm alarm that rings until acknowledged or disarmed.
module time_up_counter
  import time_up_counter_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       set_en,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       alm_en,
  input  logic [7:0] alm_hh,
  input  logic [7:0] alm_mm,
  input  logic       alm_ack,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       day_carry,
  output logic       set_err,
  output logic       alarm
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          day_carry_q, day_carry_d;
  logic          set_err_q, set_err_d;
  logic          alarm_q, alarm_d;

  logic          set_ok, step_raw, step, hour_wrap, alarm_hit;
  logic [5:0]    c;
  bcd_t          hh_nxt, mm_nxt, ss_nxt;

  always_comb begin
    set_ok    = set_en && bcd_time_valid(set_hh, set_mm, set_ss);
    step_raw  = tick_in && (presc_q == PRESC_LAST);
    // A valid load owns this edge, so any coinciding second-step is dropped.
    step      = step_raw && !set_ok;
    hour_wrap = (hh[7:4] == HOUR_TENS_MAX) && (hh[3:0] == HOUR_UNITS_TOP);
  end

  bcd_digit_up #(.WRAP(DIGIT_MAX)) u_ss_u (
    .clk(clk), .rst(rst), .cin(step), .load(set_ok), .load_val(set_ss[3:0]),
    .force_wrap(1'b0), .val(ss[3:0]), .val_nxt(ss_nxt[3:0]), .cout(c[0]));
  bcd_digit_up #(.WRAP(TENS_MAX)) u_ss_t (
    .clk(clk), .rst(rst), .cin(c[0]), .load(set_ok), .load_val(set_ss[7:4]),
    .force_wrap(1'b0), .val(ss[7:4]), .val_nxt(ss_nxt[7:4]), .cout(c[1]));
  bcd_digit_up #(.WRAP(DIGIT_MAX)) u_mm_u (
    .clk(clk), .rst(rst), .cin(c[1]), .load(set_ok), .load_val(set_mm[3:0]),
    .force_wrap(1'b0), .val(mm[3:0]), .val_nxt(mm_nxt[3:0]), .cout(c[2]));
  bcd_digit_up #(.WRAP(TENS_MAX)) u_mm_t (
    .clk(clk), .rst(rst), .cin(c[2]), .load(set_ok), .load_val(set_mm[7:4]),
    .force_wrap(1'b0), .val(mm[7:4]), .val_nxt(mm_nxt[7:4]), .cout(c[3]));
  bcd_digit_up #(.WRAP(DIGIT_MAX)) u_hh_u (
    .clk(clk), .rst(rst), .cin(c[3]), .load(set_ok), .load_val(set_hh[3:0]),
    .force_wrap(hour_wrap), .val(hh[3:0]), .val_nxt(hh_nxt[3:0]), .cout(c[4]));
  bcd_digit_up #(.WRAP(HOUR_TENS_MAX)) u_hh_t (
    .clk(clk), .rst(rst), .cin(c[4]), .load(set_ok), .load_val(set_hh[7:4]),
    .force_wrap(1'b0), .val(hh[7:4]), .val_nxt(hh_nxt[7:4]), .cout(c[5]));

  always_comb begin
    presc_d = presc_q;
    if (set_ok)
      presc_d = '0;
    else if (tick_in)
      presc_d = step_raw ? '0 : presc_q + 1'b1;

    day_carry_d = step && c[5];
    set_err_d   = set_en && !set_ok;

    // Only a counted step can ring; a non-BCD alarm time can never equal a counted time.
    alarm_hit = alm_en && step && bcd_time_valid(alm_hh, alm_mm, 8'h00) &&
                (hh_nxt == alm_hh) && (mm_nxt == alm_mm) && (ss_nxt == 8'h00);
    alarm_d = alarm_q;
    if (alarm_hit)
      alarm_d = 1'b1;
    else if (alm_ack || !alm_en)
      alarm_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q     <= '0;
      day_carry_q <= 1'b0;
      set_err_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      day_carry_q <= day_carry_d;
      set_err_q   <= set_err_d;
      alarm_q     <= alarm_d;
    end
  end

  assign day_carry = day_carry_q;
  assign set_err   = set_err_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_time_up_counter.sv
// Directed bench for time_up_counter: one instance at TICK_DIV=1 for the
// counting/load/alarm paths, one at TICK_DIV=4 for the prescaler and reset.
module tb_time_up_counter;

  logic       clk;
  logic       rst, tick_in, set_en, alm_en, alm_ack;
  logic [7:0] set_hh, set_mm, set_ss, alm_hh, alm_mm;
  logic [7:0] hh, mm, ss;
  logic       day_carry, set_err, alarm;

  logic       rst4, tick4;
  logic [7:0] hh4, mm4, ss4;
  logic       day_carry4, set_err4, alarm4;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  time_up_counter #(.TICK_DIV(1)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .set_en(set_en),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .alm_en(alm_en), .alm_hh(alm_hh), .alm_mm(alm_mm), .alm_ack(alm_ack),
    .hh(hh), .mm(mm), .ss(ss), .day_carry(day_carry), .set_err(set_err), .alarm(alarm));

  time_up_counter #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst4), .tick_in(tick4), .set_en(1'b0),
    .set_hh(8'h00), .set_mm(8'h00), .set_ss(8'h00),
    .alm_en(1'b0), .alm_hh(8'h00), .alm_mm(8'h00), .alm_ack(1'b0),
    .hh(hh4), .mm(mm4), .ss(ss4), .day_carry(day_carry4), .set_err(set_err4), .alarm(alarm4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  // driver tasks
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic check_time(input string tag, input logic [23:0] exp);
    check(tag, {8'h00, hh, mm, ss}, {8'h00, exp});
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_en = 1'b1; set_hh = h; set_mm = m; set_ss = s;
    edge1();
    set_en = 1'b0;
  endtask

  int q4, s4;

  task automatic cycle4(input string tag);
    edge1();
    if (!rst4) begin
      q4 = 0; s4 = 0;
    end else if (tick4) begin
      if (q4 == 3) begin q4 = 0; s4++; end
      else q4++;
    end
    check(tag, {24'h0, ss4}, {24'h0, to_bcd(s4)});
  endtask

  initial begin
    rst = 1'b0; tick_in = 1'b0; set_en = 1'b0; alm_en = 1'b0; alm_ack = 1'b0;
    set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00; alm_hh = 8'h00; alm_mm = 8'h00;
    rst4 = 1'b0; tick4 = 1'b0;
    #2;
    tick_in = 1'b1; set_en = 1'b1; set_hh = 8'h12; alm_ack = 1'b1;
    edge1();
    edge1();
    check_time("reset_time", 24'h000000);
    check("reset_day_carry", {31'h0, day_carry}, 32'h0);
    check("reset_set_err", {31'h0, set_err}, 32'h0);
    check("reset_alarm", {31'h0, alarm}, 32'h0);
    tick_in = 1'b0; set_en = 1'b0; alm_ack = 1'b0;
    rst = 1'b1;
    edge1();
    check_time("idle_no_tick", 24'h000000);

    // 60 seconds of counting
    tick_in = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      edge1();
      check_time("count_60", {8'h00, to_bcd(i / 60), to_bcd(i % 60)});
    end
    check_time("after_60_steps", 24'h000100);
    tick_in = 1'b0;

    // day wrap
    load(8'h23, 8'h59, 8'h58);
    check_time("load_235958", 24'h235958);
    tick_in = 1'b1;
    edge1();
    check_time("step_235959", 24'h235959);
    check("no_day_carry_yet", {31'h0, day_carry}, 32'h0);
    edge1();
    tick_in = 1'b0;
    check_time("wrap_000000", 24'h000000);
    check("day_carry_pulse", {31'h0, day_carry}, 32'h1);
    edge1();
    check("day_carry_gone", {31'h0, day_carry}, 32'h0);
    check_time("hold_000000", 24'h000000);

    // hour units wrap 19 -> 20
    load(8'h19, 8'h59, 8'h59);
    tick_in = 1'b1;
    edge1();
    tick_in = 1'b0;
    check_time("wrap_19_to_20", 24'h200000);
    check("no_day_carry_20", {31'h0, day_carry}, 32'h0);

    // rejected and accepted loads
    load(8'h12, 8'h60, 8'h00);
    check_time("bad_load_time", 24'h200000);
    check("bad_load_err", {31'h0, set_err}, 32'h1);
    load(8'h12, 8'h34, 8'h56);
    check_time("good_load_time", 24'h123456);
    check("good_load_no_err", {31'h0, set_err}, 32'h0);
    edge1();
    check("err_idle", {31'h0, set_err}, 32'h0);
    tick_in = 1'b1;
    load(8'h24, 8'h00, 8'h00);
    check_time("bad_hh24_step_runs", 24'h123457);
    check("bad_hh24_err", {31'h0, set_err}, 32'h1);
    load(8'h0A, 8'h00, 8'h00);
    check_time("bad_digit_step_runs", 24'h123458);
    check("bad_digit_err", {31'h0, set_err}, 32'h1);
    load(8'h12, 8'h34, 8'h56);
    check_time("load_suppresses_step", 24'h123456);
    check("load_clears_err", {31'h0, set_err}, 32'h0);
    tick_in = 1'b0;

    // alarm
    alm_en = 1'b1; alm_hh = 8'h07; alm_mm = 8'h00;
    load(8'h06, 8'h59, 8'h59);
    check("alarm_quiet_pre", {31'h0, alarm}, 32'h0);
    tick_in = 1'b1;
    edge1();
    tick_in = 1'b0;
    check_time("alarm_time", 24'h070000);
    check("alarm_rings", {31'h0, alarm}, 32'h1);
    edge1();
    check("alarm_holds", {31'h0, alarm}, 32'h1);
    alm_ack = 1'b1;
    edge1();
    alm_ack = 1'b0;
    check("alarm_acked", {31'h0, alarm}, 32'h0);
    load(8'h07, 8'h00, 8'h00);
    check("alarm_not_by_load", {31'h0, alarm}, 32'h0);
    load(8'h06, 8'h59, 8'h59);
    tick_in = 1'b1; alm_ack = 1'b1;
    edge1();
    tick_in = 1'b0; alm_ack = 1'b0;
    check("alarm_set_beats_ack", {31'h0, alarm}, 32'h1);
    alm_en = 1'b0;
    edge1();
    check("alarm_disarm_clears", {31'h0, alarm}, 32'h0);
    alm_en = 1'b1; alm_hh = 8'h07; alm_mm = 8'h0A;
    load(8'h07, 8'h09, 8'h59);
    tick_in = 1'b1;
    edge1();
    tick_in = 1'b0;
    check_time("bad_alarm_time", 24'h071000);
    check("bad_alarm_no_ring", {31'h0, alarm}, 32'h0);
    check("bad_alarm_no_err", {31'h0, set_err}, 32'h0);

    // prescaler at TICK_DIV=4, tick toggling
    q4 = 0; s4 = 0;
    rst4 = 1'b1;
    for (int k = 0; k < 22; k++) begin
      tick4 = (k % 2 == 0);
      cycle4("div4_count");
    end
    check("div4_two_steps", {24'h0, ss4}, 32'h02);
    tick4 = 1'b1; rst4 = 1'b0;
    cycle4("div4_reset");
    check("div4_reset_time", {8'h00, hh4, mm4, ss4}, 32'h0);
    rst4 = 1'b1;
    for (int k = 23; k < 40; k++) begin
      tick4 = (k % 2 == 1);
      cycle4("div4_restart");
    end
    check("div4_restart_two", {24'h0, ss4}, 32'h02);
    check("div4_no_set_err", {31'h0, set_err4}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
